// File: rtl/mcu_rstgen_pkg.sv
// Shared constants for the MCU system reset generator: FSM encodings,
// reset-cause bit positions and the power-on value of the cause register.
package mcu_rstgen_pkg;

    typedef enum logic [1:0] {
        RST_IDLE   = 2'd0,
        RST_HOLD   = 2'd1,
        RST_WAIT   = 2'd2,
        RST_UNUSED = 2'd3
    } rst_state_e;

    localparam int CAUSE_NRST   = 0;
    localparam int CAUSE_SYSREQ = 1;
    localparam int CAUSE_WDOG   = 2;
    localparam int CAUSE_LOCKUP = 3;
    localparam int CAUSE_POR    = 4;
    localparam int CAUSE_W      = 5;

    localparam logic [CAUSE_W-1:0] RSTCAUSE_RST = 5'b10000;

endpackage

// File: rtl/cdc_capt_sync.sv
// Two-flop synchronizer for a single asynchronous level; the reset value is
// chosen by the instantiating block so it can mean "not requested".
module cdc_capt_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic nreset,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = async_i;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/mcu_rstgen.sv
// AHB-domain system reset generator: merges pin, CPU, watchdog and lockup
// requests into a minimum-width, synchronously released HRESETn.
module mcu_rstgen
    import mcu_rstgen_pkg::*;
#(
    parameter  int HOLD_CYCLES = 16,
    localparam int CNT_W       = $clog2(HOLD_CYCLES)
) (
    input  logic                HCLK,
    input  logic                PORESETn,
    input  logic                NRST,
    input  logic                SYSRESETREQ,
    input  logic                WDOGRESETREQ,
    input  logic                LOCKUP,
    input  logic                LOCKUPRESET,
    input  logic                RSTCAUSE_CLR,
    output logic                HRESETn,
    output logic [CAUSE_W-1:0]  RSTCAUSE
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

    rst_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               hresetn_q, hresetn_d;
    logic [CAUSE_W-1:0] cause_q, cause_d;
    logic [CAUSE_W-1:0] cause_set;
    logic               nrst_sync;
    logic               nrst_req;
    logic               lockup_req;
    logic               req;

    cdc_capt_sync #(
        .RST_VAL (1'b1)
    ) u_nrst_sync (
        .clk     (HCLK),
        .nreset  (PORESETn),
        .async_i (NRST),
        .sync_o  (nrst_sync)
    );

    always_comb begin
        nrst_req   = ~nrst_sync;
        lockup_req = LOCKUP & LOCKUPRESET;
        req        = nrst_req | SYSRESETREQ | WDOGRESETREQ | lockup_req;

        cause_set               = '0;
        cause_set[CAUSE_NRST]   = nrst_req;
        cause_set[CAUSE_SYSREQ] = SYSRESETREQ;
        cause_set[CAUSE_WDOG]   = WDOGRESETREQ;
        cause_set[CAUSE_LOCKUP] = lockup_req;
        // Set has priority over clear so a cause arriving with the strobe is kept.
        cause_d = (RSTCAUSE_CLR ? '0 : cause_q) | cause_set;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RST_IDLE: begin
                if (req) begin
                    state_d = RST_HOLD;
                    cnt_d   = CNT_LOAD;
                end
            end
            RST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = req ? RST_WAIT : RST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RST_WAIT: begin
                if (!req) begin
                    state_d = RST_IDLE;
                end
            end
            default: begin
                state_d = RST_HOLD;
                cnt_d   = CNT_LOAD;
            end
        endcase
        hresetn_d = (state_d == RST_IDLE);
    end

    always_ff @(posedge HCLK or negedge PORESETn) begin
        if (!PORESETn) begin
            state_q   <= RST_HOLD;
            cnt_q     <= CNT_LOAD;
            hresetn_q <= 1'b0;
            cause_q   <= RSTCAUSE_RST;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hresetn_q <= hresetn_d;
            cause_q   <= cause_d;
        end
    end

    assign HRESETn  = hresetn_q;
    assign RSTCAUSE = cause_q;

endmodule

// File: tb/tb_mcu_rstgen.sv
// Scoreboard bench for mcu_rstgen: directed requests push expected HRESETn
// transitions and cause snapshots; a negedge monitor pops and compares them.
module tb_mcu_rstgen;

    logic       HCLK = 1'b0;
    logic       PORESETn;
    logic       NRST;
    logic       SYSRESETREQ;
    logic       WDOGRESETREQ;
    logic       LOCKUP;
    logic       LOCKUPRESET;
    logic       RSTCAUSE_CLR;
    logic       HRESETn;
    logic [4:0] RSTCAUSE;

    typedef struct {
        logic lvl;
        int   cyc;
    } edge_t;

    typedef struct {
        string      name;
        logic       h;
        logic [4:0] cause;
    } chk_t;

    edge_t edgeQ[$];
    chk_t  chkQ[$];

    int   cyc         = 0;
    int   vectors     = 0;
    int   miscompares = 0;
    logic monEn       = 1'b0;
    logic prevLvl     = 1'b0;

    mcu_rstgen #(
        .HOLD_CYCLES (16)
    ) dut (
        .HCLK         (HCLK),
        .PORESETn     (PORESETn),
        .NRST         (NRST),
        .SYSRESETREQ  (SYSRESETREQ),
        .WDOGRESETREQ (WDOGRESETREQ),
        .LOCKUP       (LOCKUP),
        .LOCKUPRESET  (LOCKUPRESET),
        .RSTCAUSE_CLR (RSTCAUSE_CLR),
        .HRESETn      (HRESETn),
        .RSTCAUSE     (RSTCAUSE)
    );

    always #5 HCLK = ~HCLK;

    always @(posedge HCLK) cyc <= cyc + 1;

    // Monitor: every HRESETn transition must match the next expected edge
    // (level and the clock edge it happened after); queued snapshots are
    // compared against the live outputs.
    always @(negedge HCLK) begin
        edge_t e;
        chk_t  c;
        if (monEn) begin
            if (HRESETn !== prevLvl) begin
                vectors++;
                if (edgeQ.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL hresetn_edge: HRESETn went to %b after edge %0d, expected no transition",
                             HRESETn, cyc);
                end else begin
                    e = edgeQ.pop_front();
                    if (e.lvl !== HRESETn || e.cyc != cyc) begin
                        miscompares++;
                        $display("[TB] FAIL hresetn_edge: HRESETn=%b after edge %0d, expected %b after edge %0d",
                                 HRESETn, cyc, e.lvl, e.cyc);
                    end
                end
                prevLvl = HRESETn;
            end
            while (chkQ.size() > 0) begin
                c = chkQ.pop_front();
                vectors++;
                if (HRESETn !== c.h || RSTCAUSE !== c.cause) begin
                    miscompares++;
                    $display("[TB] FAIL %s: HRESETn=%b RSTCAUSE=%b, expected HRESETn=%b RSTCAUSE=%b",
                             c.name, HRESETn, RSTCAUSE, c.h, c.cause);
                end
            end
        end
    end

    task automatic waitEdges(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    task automatic expectEdge(input logic lvl, input int atCyc);
        edgeQ.push_back('{lvl, atCyc});
    endtask

    // Queue a snapshot; the monitor compares it at the coming negedge.
    task automatic checkOutput(input string name, input logic expH, input logic [4:0] expCause);
        chkQ.push_back('{name, expH, expCause});
        waitEdges(1);
    endtask

    // mask: [0] NRST low, [1] SYSRESETREQ, [2] WDOGRESETREQ, [3] LOCKUP+LOCKUPRESET.
    // fallOff/riseOff are hand-computed edge offsets from the drive point.
    task automatic applyStimulus(input string name, input logic [3:0] mask, input int hold,
                                 input int fallOff, input int riseOff,
                                 input logic [4:0] expCause, input bit clrAfter);
        int c;
        c = cyc;
        if (mask[0]) NRST = 1'b0;
        SYSRESETREQ  = mask[1];
        WDOGRESETREQ = mask[2];
        if (mask[3]) begin
            LOCKUP      = 1'b1;
            LOCKUPRESET = 1'b1;
        end
        expectEdge(1'b0, c + fallOff);
        expectEdge(1'b1, c + riseOff);
        waitEdges(hold);
        NRST         = 1'b1;
        SYSRESETREQ  = 1'b0;
        WDOGRESETREQ = 1'b0;
        if (mask[3]) begin
            LOCKUP      = 1'b0;
            LOCKUPRESET = 1'b0;
        end
        waitEdges(riseOff - hold + 3);
        checkOutput(name, 1'b1, expCause);
        if (clrAfter) begin
            RSTCAUSE_CLR = 1'b1;
            waitEdges(1);
            RSTCAUSE_CLR = 1'b0;
            waitEdges(1);
            checkOutput({name, "_clr"}, 1'b1, 5'b00000);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not complete, expected finish before 200000 time units");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int   c;
        int   d;
        edge_t e;
        PORESETn     = 1'b0;
        NRST         = 1'b1;
        SYSRESETREQ  = 1'b0;
        WDOGRESETREQ = 1'b0;
        LOCKUP       = 1'b0;
        LOCKUPRESET  = 1'b0;
        RSTCAUSE_CLR = 1'b0;
        waitEdges(3);
        prevLvl = 1'b0;
        monEn   = 1'b1;

        checkOutput("por_state", 1'b0, 5'b10000);

        // Power-on release: HRESETn rises 16 edges after PORESETn deasserts.
        c = cyc;
        PORESETn = 1'b1;
        expectEdge(1'b1, c + 16);
        waitEdges(20);
        checkOutput("por_release", 1'b1, 5'b10000);

        applyStimulus("sys_pulse",   4'b0010,  1, 1, 17, 5'b10010, 1'b1);
        applyStimulus("wdog_hold40", 4'b0100, 40, 1, 41, 5'b00100, 1'b1);

        // Lockup without the enable must not reset nor record a cause.
        LOCKUP      = 1'b1;
        LOCKUPRESET = 1'b0;
        waitEdges(20);
        checkOutput("lockup_gated", 1'b1, 5'b00000);
        applyStimulus("lockup_enabled", 4'b1000, 2, 1, 17, 5'b01000, 1'b1);

        // NRST: two synchronizer edges plus one register edge.
        applyStimulus("nrst_low3", 4'b0001, 3, 3, 19, 5'b00001, 1'b0);

        // Clear coinciding with a new SYSRESETREQ keeps only that cause.
        c = cyc;
        SYSRESETREQ  = 1'b1;
        RSTCAUSE_CLR = 1'b1;
        expectEdge(1'b0, c + 1);
        expectEdge(1'b1, c + 17);
        waitEdges(1);
        SYSRESETREQ  = 1'b0;
        RSTCAUSE_CLR = 1'b0;
        waitEdges(19);
        checkOutput("clr_vs_sys", 1'b1, 5'b00010);

        // Power-on reset while the FSM sits in WAIT.
        c = cyc;
        WDOGRESETREQ = 1'b1;
        expectEdge(1'b0, c + 1);
        waitEdges(20);
        checkOutput("wait_state", 1'b0, 5'b00110);
        PORESETn     = 1'b0;
        WDOGRESETREQ = 1'b0;
        checkOutput("por_in_wait", 1'b0, 5'b10000);
        d = cyc;
        PORESETn = 1'b1;
        expectEdge(1'b1, d + 16);
        waitEdges(14);
        checkOutput("por_hold_min", 1'b0, 5'b10000);
        waitEdges(4);
        checkOutput("por_wait_release", 1'b1, 5'b10000);

        // Asynchronous assertion from IDLE: HRESETn drops before the next edge.
        c = cyc;
        PORESETn = 1'b0;
        expectEdge(1'b0, c);
        waitEdges(2);
        d = cyc;
        PORESETn = 1'b1;
        expectEdge(1'b1, d + 16);
        waitEdges(20);
        checkOutput("por_idle_release", 1'b1, 5'b10000);

        waitEdges(3);
        while (edgeQ.size() > 0) begin
            e = edgeQ.pop_front();
            vectors++;
            miscompares++;
            $display("[TB] FAIL hresetn_edge: no transition seen, expected %b after edge %0d", e.lvl, e.cyc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
